// File: rtl/cmp4_sort_ctrl_if.sv
// Streaming load/drain handshake bundle for cmp4_sort_ctrl.
// The producer/consumer side takes the master modport; the sorter takes the slave modport.
interface cmp4_sort_ctrl_if #(
    parameter int W = 4
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/cmp4_sort_ctrl.sv
// Burst bubble-sorter: loads N values, sorts them in place using one external comparator
// (one compare per clock), then streams them out smallest first.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_LOAD  | accepting N values from the producer into mem
// ST_SORT  | one compare/optional swap of mem[idx], mem[idx+1] per cycle
// ST_DRAIN | streaming mem[0..N-1] to the consumer
module cmp4_sort_ctrl #(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    cmp4_sort_ctrl_if.slave bus,
    output logic         busy,
    output logic [W-1:0] cmp_a,
    output logic [W-1:0] cmp_b,
    input  logic         cmp_less,
    input  logic         cmp_equal,
    input  logic         cmp_greater
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] PEN  = CW'(N - 2);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_SORT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] wr, idx, pass, rd;
    logic [CW-1:0] idx_nx, rd_nx;
    logic          swapped;
    logic [W-1:0]  mem [N];
    logic [W-1:0]  out_q;

    logic load_fire, drain_fire, sort_swap, pass_end, more_pass, sort_done;

    assign idx_nx     = idx + CW'(1);
    assign rd_nx      = rd + CW'(1);
    assign load_fire  = (state == ST_LOAD) && bus.in_valid;
    assign drain_fire = (state == ST_DRAIN) && bus.out_ready;
    assign sort_swap  = (state == ST_SORT) && cmp_greater;
    assign pass_end   = (idx == PEN);
    assign more_pass  = (swapped || cmp_greater) && (pass < PEN);
    assign sort_done  = (state == ST_SORT) && pass_end && !more_pass;

    assign cmp_a = mem[idx];
    assign cmp_b = mem[idx_nx];

    assign bus.in_ready  = (state == ST_LOAD);
    assign bus.out_valid = (state == ST_DRAIN);
    assign bus.out_last  = (state == ST_DRAIN) && (rd == LAST);
    assign bus.out_data  = out_q;
    assign busy          = (state == ST_SORT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_LOAD;
            wr      <= '0;
            idx     <= '0;
            pass    <= '0;
            rd      <= '0;
            swapped <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (bus.in_valid) begin
                        if (wr == LAST) begin
                            state   <= ST_SORT;
                            idx     <= '0;
                            pass    <= '0;
                            swapped <= 1'b0;
                        end else begin
                            wr <= wr + CW'(1);
                        end
                    end
                end
                ST_SORT: begin
                    if (!pass_end) begin
                        idx <= idx_nx;
                        if (cmp_greater) swapped <= 1'b1;
                    end else if (more_pass) begin
                        idx     <= '0;
                        pass    <= pass + CW'(1);
                        swapped <= 1'b0;
                    end else begin
                        state <= ST_DRAIN;
                        rd    <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (bus.out_ready) begin
                        if (rd == LAST) begin
                            state <= ST_LOAD;
                            wr    <= '0;
                        end else begin
                            rd <= rd_nx;
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    // Storage and read register carry no reset; a swap landing on entry 0 in the
    // final compare must be forwarded into the first output word.
    always_ff @(posedge clk) begin
        if (load_fire) mem[wr] <= bus.in_data;
        if (sort_swap) begin
            mem[idx]    <= cmp_b;
            mem[idx_nx] <= cmp_a;
        end
        if (sort_done)
            out_q <= (sort_swap && idx == '0) ? cmp_b : mem[0];
        else if (drain_fire && rd != LAST)
            out_q <= mem[rd_nx];
    end

    a_cmp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        (state == ST_SORT) |-> $onehot({cmp_less, cmp_equal, cmp_greater}));

endmodule

// File: tb/tb_cmp4_sort_ctrl.sv
// Bench for cmp4_sort_ctrl: supplies the external comparator and checks bursts against
// a sorted-queue model, including SORT duration, output stalls and mid-sort reset.
module tb_cmp4_sort_ctrl;
    localparam int N = 8;
    localparam int W = 4;

    typedef logic [W-1:0] burst_t [N];

    logic         clk = 1'b0;
    logic         rst_n;
    logic         busy;
    logic [W-1:0] cmp_a, cmp_b;
    logic         cmp_less, cmp_equal, cmp_greater;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    int onehot_bad = 0;

    cmp4_sort_ctrl_if #(.W(W)) bus ();

    cmp4_sort_ctrl #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .cmp_a       (cmp_a),
        .cmp_b       (cmp_b),
        .cmp_less    (cmp_less),
        .cmp_equal   (cmp_equal),
        .cmp_greater (cmp_greater)
    );

    assign cmp_less    = (cmp_a < cmp_b);
    assign cmp_equal   = (cmp_a == cmp_b);
    assign cmp_greater = (cmp_a > cmp_b);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (busy === 1'b1) begin
            busy_cnt++;
            if (!$onehot({cmp_less, cmp_equal, cmp_greater})) onehot_bad++;
        end
    end

    // Early-exit bubble sort needs one pass per step of the largest leftward move
    // any element must make, plus a final clean pass, capped at N-1 passes.
    function automatic int exp_busy_cycles(input burst_t b);
        int worst = 0;
        int p;
        for (int i = 0; i < N; i++) begin
            int c = 0;
            for (int j = 0; j < i; j++) if (b[j] > b[i]) c++;
            if (c > worst) worst = c;
        end
        p = worst + 1;
        if (p > N - 1) p = N - 1;
        return p * (N - 1);
    endfunction

    task automatic load_burst(input burst_t b, input bit junk);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL load_in_ready[%0d]: got %b expected 1", i, bus.in_ready);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = b[i];
            bus.out_ready = junk;
            @(negedge clk);
        end
        bus.in_valid = junk;
    endtask

    task automatic run_burst(input burst_t b, input int mode, input bit junk, input string name);
        int q[$];
        logic [W-1:0] got_d[$];
        logic         got_l[$];
        int start, cyc, exp_b;
        bit prev_stall;
        logic [W-1:0] prev_d;
        logic prev_l;
        logic rdy;

        for (int i = 0; i < N; i++) q.push_back(int'(b[i]));
        q.sort();
        exp_b = exp_busy_cycles(b);
        start = busy_cnt;

        load_burst(b, junk);

        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 100) begin
            if (junk) bus.in_data = W'($urandom_range(0, 15));
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s sort_timeout: got out_valid %b after %0d cycles expected 1", name, bus.out_valid, cyc);
        end

        cyc = 0;
        prev_stall = 1'b0;
        prev_d = '0;
        prev_l = 1'b0;
        while (got_d.size() < N && cyc < 300) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = rdy;
            if (junk) bus.in_data = W'($urandom_range(0, 15));
            checks++;
            if (bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s drain_valid: got %b expected 1 at item %0d", name, bus.out_valid, got_d.size());
            end
            if (prev_stall) begin
                checks++;
                if (bus.out_data !== prev_d || bus.out_last !== prev_l) begin
                    errors++;
                    $display("FAIL %s stall_hold: got %0d/%b expected %0d/%b", name, bus.out_data, bus.out_last, prev_d, prev_l);
                end
            end
            if (rdy) begin
                got_d.push_back(bus.out_data);
                got_l.push_back(bus.out_last);
                prev_stall = 1'b0;
            end else begin
                prev_stall = 1'b1;
                prev_d = bus.out_data;
                prev_l = bus.out_last;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;

        checks++;
        if (got_d.size() != N) begin
            errors++;
            $display("FAIL %s drain_count: got %0d expected %0d", name, got_d.size(), N);
        end
        for (int i = 0; i < got_d.size(); i++) begin
            checks++;
            if (int'(got_d[i]) != q[i] || got_l[i] !== (i == N - 1)) begin
                errors++;
                $display("FAIL %s out[%0d]: got %0d last %b expected %0d last %b", name, i, got_d[i], got_l[i], q[i], (i == N - 1));
            end
        end
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s back_to_load: got in_ready %b out_valid %b expected 1 0", name, bus.in_ready, bus.out_valid);
        end
        checks++;
        if (busy_cnt - start != exp_b) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt - start, exp_b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got in_ready %b out_valid %b out_last %b busy %b expected 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_last, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        burst_t b = '{4'd8, 4'd3, 4'd15, 4'd0, 4'd7, 4'd7, 4'd1, 4'd12};
        run_burst(b, 0, 1'b0, "t1_basic");
    endtask

    task automatic test_presorted();
        burst_t b = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        run_burst(b, 0, 1'b0, "t2_presorted");
    endtask

    task automatic test_reversed();
        burst_t b = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8};
        run_burst(b, 0, 1'b0, "t3_reversed");
    endtask

    task automatic test_equal_stall();
        burst_t b = '{default: 4'd5};
        run_burst(b, 1, 1'b0, "t4_equal_stall");
    endtask

    task automatic test_reset_mid_sort();
        burst_t b = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8};
        burst_t t1 = '{4'd8, 4'd3, 4'd15, 4'd0, 4'd7, 4'd7, 4'd1, 4'd12};
        int start, cyc;
        start = busy_cnt;
        load_burst(b, 1'b0);
        cyc = 0;
        while (busy_cnt - start < 10 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL t5_in_sort: got busy %b expected 1", busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t5_after_reset: got in_ready %b out_valid %b busy %b expected 1 0 0",
                     bus.in_ready, bus.out_valid, busy);
        end
        run_burst(t1, 0, 1'b0, "t5_fresh");
    endtask

    task automatic test_back_to_back();
        burst_t b;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) b[i] = W'($urandom_range(0, 15));
            run_burst(b, k, 1'b1, "t6_b2b_junk");
        end
    endtask

    task automatic test_random();
        burst_t b;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N; i++) b[i] = W'($urandom_range(0, 15));
            run_burst(b, 2, 1'b0, "random");
        end
    endtask

    task automatic test_onehot();
        checks++;
        if (onehot_bad != 0) begin
            errors++;
            $display("FAIL cmp_onehot: got %0d bad SORT cycles expected 0", onehot_bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_presorted();
        test_reversed();
        test_equal_stall();
        test_reset_mid_sort();
        test_back_to_back();
        test_random();
        test_onehot();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
